// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx among N_REQ byte streams
module uart_tx_arbiter #(
  parameter int N_REQ     = 3,
  parameter int MAX_BYTES = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_din,
  input  logic               tx_done,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               abort
);
  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, LOAD, WAIT} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, gidx, sel, gnext;
  logic [BW-1:0]   bcnt;
  logic [TW-1:0]   tcnt;
  logic            last_flag, v_g, tmo, rel;

  assign v_g   = req_valid[gidx];
  assign tmo   = tcnt == TW'(TIMEOUT);
  assign rel   = last_flag || bcnt == BW'(MAX_BYTES);
  assign gnext = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
  assign busy  = |grant;

  // Scanning downward lets the lowest offset from ptr win without an early exit.
  always_comb begin
    sel = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_valid[(int'(ptr) + i) % N_REQ]) sel = PW'((int'(ptr) + i) % N_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    tx_start  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE:  state_nx = |req_valid ? GRANT : IDLE;
      GRANT: begin
        req_ready = req_valid & grant;
        abort     = !v_g && tmo;
        state_nx  = v_g ? LOAD : (tmo ? IDLE : GRANT);
      end
      LOAD: begin
        tx_start = 1'b1;
        state_nx = WAIT;
      end
      WAIT:    state_nx = !tx_done ? WAIT : (rel ? IDLE : GRANT);
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      gidx      <= '0;
      grant     <= '0;
      bcnt      <= '0;
      tcnt      <= '0;
      tx_din    <= '0;
      last_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          grant <= N_REQ'(1) << sel;
          gidx  <= sel;
          bcnt  <= '0;
          tcnt  <= '0;
        end
        GRANT: if (v_g) begin
          tx_din    <= req_data[8*gidx +: 8];
          last_flag <= req_last[gidx];
          bcnt      <= bcnt + 1'b1;
          tcnt      <= '0;
        end else if (tmo) begin
          grant <= '0;
          ptr   <= gnext;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        WAIT: if (tx_done && rel) begin
          grant <= '0;
          ptr   <= gnext;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: cycle vectors for one packet, then queue-driven requesters with a uart_tx stand-in
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_last, req_ready, grant;
  logic [23:0] req_data;
  logic        tx_start, tx_done, busy, abort;
  logic [7:0]  tx_din;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din), .tx_done(tx_done),
    .grant(grant), .busy(busy), .abort(abort)
  );

  typedef struct {
    logic [2:0]  v;
    logic [23:0] d;
    logic [2:0]  l;
    logic        dn;
    logic [2:0]  rdy;
    logic        st;
    logic [7:0]  din;
    logic [2:0]  g;
    logic        b;
    logic        ab;
  } vec_t;

  vec_t        tv[12];
  int          errors = 0, checks = 0, cyc_n = 0, n_start = 0, n_abort = 0;
  int          last_done = 0, abort_gap = 0, dcnt = 0, ns, k;
  logic        inj = 1'b0, gclr = 1'b0, snap_busy = 1'b0;
  logic [16:0] snap;
  logic [8:0]  q0[$], q1[$], q2[$];
  logic [9:0]  log_q[$], exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive();
    req_valid = {q2.size() > 0, q1.size() > 0, q0.size() > 0};
    req_data  = {req_valid[2] ? q2[0][7:0] : 8'h0, req_valid[1] ? q1[0][7:0] : 8'h0,
                 req_valid[0] ? q0[0][7:0] : 8'h0};
    req_last  = {req_valid[2] ? q2[0][8] : 1'b0, req_valid[1] ? q1[0][8] : 1'b0,
                 req_valid[0] ? q0[0][8] : 1'b0};
  endtask

  task automatic cyc();
    logic [2:0] r;
    logic       st;
    int         ow;
    @(negedge clk);
    snap      = {req_ready, tx_start, tx_din, grant, busy, abort};
    snap_busy = busy;
    if (!rst) begin
      chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      chk("ready_owner", 32'(req_ready & ~grant), 32'd0);
      chk("busy_grant", 32'(busy), 32'(|grant));
    end
    if (gclr) chk("abort_grant_clr", 32'(grant), 32'd0);
    gclr = abort && !rst;
    if (tx_start) begin
      ow = 0;
      for (int i = 0; i < 3; i++) if (grant[i]) ow = i;
      log_q.push_back({ow[1:0], tx_din});
      n_start++;
    end
    if (abort) begin
      n_abort++;
      abort_gap = cyc_n - last_done;
    end
    if (tx_done) last_done = cyc_n;
    r  = req_ready;
    st = tx_start;
    @(posedge clk);
    #1;
    cyc_n++;
    if (r[0] && q0.size() > 0) q0.delete(0);
    if (r[1] && q1.size() > 0) q1.delete(0);
    if (r[2] && q2.size() > 0) q2.delete(0);
    drive();
    tx_done = inj;
    inj = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) tx_done = 1'b1;
    end
    if (st) dcnt = 3;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    gclr = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    drive();
    dcnt = 0;
    cyc();
    rst = 1'b0;
    cyc();
    chk("reset_outputs", 32'(snap), 32'd0);
    dcnt = 0;
    gclr = 1'b0;
    log_q.delete();
    n_abort = 0;
  endtask

  task automatic run(input int n, input int budget);
    int kk = 0;
    while (kk < budget && !(log_q.size() >= n && !snap_busy && q0.size() == 0 &&
                            q1.size() == 0 && q2.size() == 0 && dcnt == 0)) begin
      cyc();
      kk++;
    end
    chk("run_budget", 32'(kk < budget), 32'd1);
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk(nm, 32'(log_q[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    //        valid   data        last    dn    ready   st    din    grant   busy  abort
    tv[0]  = '{3'b010, 24'h005500, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0};
    tv[1]  = '{3'b010, 24'h005500, 3'b000, 1'b1, 3'b010, 1'b0, 8'h00, 3'b010, 1'b1, 1'b0};
    tv[2]  = '{3'b010, 24'h00A300, 3'b010, 1'b0, 3'b000, 1'b1, 8'h55, 3'b010, 1'b1, 1'b0};
    tv[3]  = '{3'b010, 24'h00A300, 3'b010, 1'b0, 3'b000, 1'b0, 8'h55, 3'b010, 1'b1, 1'b0};
    tv[4]  = '{3'b010, 24'h00A300, 3'b010, 1'b1, 3'b000, 1'b0, 8'h55, 3'b010, 1'b1, 1'b0};
    tv[5]  = '{3'b010, 24'h00A300, 3'b010, 1'b0, 3'b010, 1'b0, 8'h55, 3'b010, 1'b1, 1'b0};
    tv[6]  = '{3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b1, 8'hA3, 3'b010, 1'b1, 1'b0};
    tv[7]  = '{3'b000, 24'h000000, 3'b000, 1'b0, 3'b000, 1'b0, 8'hA3, 3'b010, 1'b1, 1'b0};
    tv[8]  = '{3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'hA3, 3'b010, 1'b1, 1'b0};
    tv[9]  = '{3'b000, 24'h000000, 3'b000, 1'b0, 3'b000, 1'b0, 8'hA3, 3'b000, 1'b0, 1'b0};
    tv[10] = '{3'b101, 24'h770011, 3'b101, 1'b0, 3'b000, 1'b0, 8'hA3, 3'b000, 1'b0, 1'b0};
    tv[11] = '{3'b101, 24'h770011, 3'b101, 1'b0, 3'b100, 1'b0, 8'hA3, 3'b100, 1'b1, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", 32'({req_ready, tx_start, tx_din, grant, busy, abort}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req_valid = tv[i].v; req_data = tv[i].d; req_last = tv[i].l; tx_done = tv[i].dn;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'({req_ready, tx_start, tx_din, grant, busy, abort}),
          32'({tv[i].rdy, tv[i].st, tv[i].din, tv[i].g, tv[i].b, tv[i].ab}));
      @(posedge clk);
      #1;
    end
    tx_done = 1'b0;
    do_rst();
    // contention: rotation 0,1,2 then wraps back to 0 ahead of 1
    q0 = '{9'h1AA}; q1 = '{9'h1BB}; q2 = '{9'h1CC};
    drive();
    run(3, 200);
    q0 = '{9'h1A0}; q1 = '{9'h1B0};
    drive();
    run(5, 200);
    exp_q = '{10'h0AA, 10'h1BB, 10'h2CC, 10'h0A0, 10'h1B0};
    chk_log("contention");
    do_rst();
    q0 = '{9'h001, 9'h002, 9'h103}; q2 = '{9'h1C0};
    drive();
    run(4, 300);
    exp_q = '{10'h001, 10'h002, 10'h003, 10'h2C0};
    chk_log("packet_lock");
    do_rst();
    q0 = '{9'h010}; q1 = '{9'h120};
    drive();
    run(2, 1000);
    chk("timeout_aborts", 32'(n_abort), 32'd1);
    chk("timeout_gap", 32'(abort_gap), 32'd256);
    exp_q = '{10'h010, 10'h120};
    chk_log("timeout");
    do_rst();
    for (int i = 0; i < 20; i++) q2.push_back({i == 19, 8'(8'h80 + i)});
    drive();
    repeat (3) cyc();
    q1.push_back(9'h1F1);
    drive();
    run(21, 2000);
    for (int i = 0; i < 16; i++) exp_q.push_back({2'd2, 8'(8'h80 + i)});
    exp_q.push_back(10'h1F1);
    for (int i = 16; i < 20; i++) exp_q.push_back({2'd2, 8'(8'h80 + i)});
    chk_log("max_len");
    chk("max_len_no_abort", 32'(n_abort), 32'd0);
    // reset mid-WAIT after the pointer has moved off 0
    do_rst();
    q0 = '{9'h1D0};
    drive();
    run(1, 200);
    q1 = '{9'h1D1};
    drive();
    ns = n_start;
    k = 0;
    while (n_start == ns && k < 50) begin
      cyc();
      k++;
    end
    chk("midwait_start_seen", 32'(n_start), 32'(ns + 1));
    cyc();
    inj = 1'b1;
    do_rst();
    ns = n_start;
    repeat (5) cyc();
    chk("stale_done_no_start", 32'(n_start), 32'(ns));
    q0 = '{9'h1E0}; q1 = '{9'h1E1};
    drive();
    run(2, 200);
    exp_q = '{10'h0E0, 10'h1E1};
    chk_log("post_reset_ptr");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
